fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameters SHALL be: REG_W, default 5, register-index width; MUL_LAT, default 4, multicycle-op latency in cycles (>=1); ZERO_REG, default 1, 1 = index 0 is hard-wired zero and never forwarded.
REQ-002 Ports SHALL be, in order:
clk_i  in  1  clock.
rst_i  in  1  asynchronous active-high reset.
flush_i  in  1  squash the ID-stage instruction (bubble into EX).
id_rs_i  in  REG_W  ID source A index.
id_rt_i  in  REG_W  ID source B index.
id_rd_i  in  REG_W  ID destination index.
id_we_i  in  1  ID instruction writes a register.
id_load_i  in  1  ID instruction is a load.
id_mul_i  in  1  ID instruction is a multicycle op.
id_use_rt_i  in  1  ID instruction reads rt.
fwd_a_o  out  2  EX operand A select.
fwd_b_o  out  2  EX operand B select.
stall_o  out  1  hold PC and IF/ID; ID/EX must not load.
mul_busy_o  out  1  multicycle op occupying EX.
REQ-003 Select encoding SHALL be 00 = register file, 01 = MEM/WB, 10 = EX/MEM; 11 SHALL never be driven.

Function
REQ-004 Block SHALL hold three internal slots: EX {v,rs,rt,rd,we,load,mul}, MEM {v,rd,we}, WB {v,rd,we}.
REQ-005 On an advance cycle (no freeze): WB<=MEM, MEM<=EX, EX<=ID fields with v=1, or v=0 when stall_o or flush_i.
REQ-006 Load-use: stall_o SHALL be 1 when EX.v, EX.load, EX.we, EX.rd matches id_rs_i, or matches id_rt_i with id_use_rt_i; match on index 0 SHALL not count when ZERO_REG=1.
REQ-007 Mul freeze: when a mul enters EX, a counter SHALL load MUL_LAT-1; while counter != 0: EX holds, MEM<=bubble, WB<=MEM, stall_o=1, mul_busy_o=1, counter decrements; MUL_LAT=1 SHALL cause no freeze.
REQ-008 fwd_a_o: 10 if MEM.v, MEM.we, MEM.rd==EX.rs (rd!=0 when ZERO_REG); else 01 on same test against WB; else 00; fwd_b_o identical against EX.rt.
REQ-009 Selects SHALL be 00 whenever EX.v=0.
REQ-010 Selects SHALL be valid on the first EX cycle of an instruction; the datapath latches multicycle operands then; later freeze-cycle values are don't-care.
REQ-011 flush_i SHALL be sampled only on advance cycles; during a mul freeze it is ignored and the requester holds it.
REQ-012 Mul freeze SHALL dominate load-use; both may assert stall_o in the same cycle with no extra bubble.
REQ-013 All outputs SHALL be combinational from slot state, counter and ID inputs; no output latency beyond that.

Reset
REQ-014 rst_i SHALL asynchronously clear all slot valid bits and the counter; fwd_a_o=fwd_b_o=00, stall_o=0, mul_busy_o=0 while asserted and after release.
REQ-015 Reset asserted mid-freeze SHALL abort the freeze; the first post-reset cycle is an advance cycle.

Structure
REQ-016 Package fwd_pkg SHALL hold FWD_NONE/FWD_WB/FWD_MEM constants and the slot record types.
REQ-017 One sub-module fwd_sel (priority compare of one source index against MEM and WB slots) SHALL be instantiated twice.

Verification
REQ-018 add r3 then add r4,r3,r5 -> fwd_a_o=10 in second add's EX cycle; with one nop between -> 01.
REQ-019 lw r2 then add r6,r2,r2 -> stall_o=1 one cycle, bubble in EX, then fwd_a_o=fwd_b_o=01.
REQ-020 add r0 (we=1) then add r7,r0,r0 -> selects 00 with ZERO_REG=1; 10 with ZERO_REG=0.
REQ-021 MUL_LAT=4, mul r8 -> stall_o=mul_busy_o=1 for exactly 3 cycles, MEM shows 3 bubbles, next consumer of r8 gets fwd 10.
REQ-022 rst_i pulsed on second freeze cycle -> outputs 0 immediately, no residual stall after release.
REQ-023 flush_i with a load in ID -> no load-use stall next cycle; flush_i held during mul freeze -> applied on first advance cycle.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared select encoding, pipeline slot records and index-match helpers
// for the EX-stage forwarding scoreboard.
package fwd_pkg;

   // Slot index fields are stored at a fixed width; REG_W up to IDX_W is supported.
   localparam int unsigned IDX_W = 16;

   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic v;
      idx_t rs;
      idx_t rt;
      idx_t rd;
      logic we;
      logic load;
      logic mul;
   } ex_slot_t;

   typedef struct packed {
      logic v;
      idx_t rd;
      logic we;
   } pipe_slot_t;

   function automatic logic idx_hit(idx_t a, idx_t b, logic zero_reg);
      return (a == b) && !(zero_reg && (a == '0));
   endfunction

   function automatic logic slot_hit(pipe_slot_t s, idx_t src, logic zero_reg);
      return s.v && s.we && idx_hit(s.rd, src, zero_reg);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Priority forward select for one EX source operand: MEM beats WB beats
// the register file; nothing is forwarded to an empty EX slot.
module fwd_sel
   import fwd_pkg::*;
#(
   parameter int ZERO_REG = 1
) (
   input  logic       ex_v_i,
   input  idx_t       src_i,
   input  pipe_slot_t mem_i,
   input  pipe_slot_t wb_i,
   output logic [1:0] sel_o
);

   localparam logic ZR = (ZERO_REG != 0);

   always_comb begin
      sel_o = FWD_NONE;
      if (ex_v_i) begin
         if (slot_hit(mem_i, src_i, ZR)) begin
            sel_o = FWD_MEM;
         end else if (slot_hit(wb_i, src_i, ZR)) begin
            sel_o = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// EX/MEM/WB occupancy tracker producing operand forward selects, load-use
// stalls and a multicycle-op freeze for a classic 5-stage pipeline.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int MUL_LAT  = 4,
   parameter int ZERO_REG = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic [REG_W-1:0] id_rd_i,
   input  logic             id_we_i,
   input  logic             id_load_i,
   input  logic             id_mul_i,
   input  logic             id_use_rt_i,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic             stall_o,
   output logic             mul_busy_o
);

   localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);
   localparam logic        ZR    = (ZERO_REG != 0);

   ex_slot_t   ex_q, ex_d;
   pipe_slot_t mem_q, mem_d;
   pipe_slot_t wb_q, wb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic freeze;
   logic load_use;

   always_comb begin
      freeze   = (cnt_q != '0);
      load_use = ex_q.v && ex_q.load && ex_q.we &&
                 (idx_hit(ex_q.rd, idx_t'(id_rs_i), ZR) ||
                  (id_use_rt_i && idx_hit(ex_q.rd, idx_t'(id_rt_i), ZR)));

      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = mem_q;
      cnt_d = cnt_q;

      if (freeze) begin
         // Multicycle op keeps EX; the pipe behind it drains bubbles.
         mem_d = '0;
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         mem_d.v  = ex_q.v;
         mem_d.rd = ex_q.rd;
         mem_d.we = ex_q.we;
         if (load_use || flush_i) begin
            ex_d = '0;
         end else begin
            ex_d.v    = 1'b1;
            ex_d.rs   = idx_t'(id_rs_i);
            ex_d.rt   = idx_t'(id_rt_i);
            ex_d.rd   = idx_t'(id_rd_i);
            ex_d.we   = id_we_i;
            ex_d.load = id_load_i;
            ex_d.mul  = id_mul_i;
         end
         if (ex_d.v && ex_d.mul) begin
            cnt_d = CNT_W'(MUL_LAT - 1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

   fwd_sel #(
      .ZERO_REG(ZERO_REG)
   ) u_sel_a (
      .ex_v_i(ex_q.v),
      .src_i (ex_q.rs),
      .mem_i (mem_q),
      .wb_i  (wb_q),
      .sel_o (fwd_a_o)
   );

   fwd_sel #(
      .ZERO_REG(ZERO_REG)
   ) u_sel_b (
      .ex_v_i(ex_q.v),
      .src_i (ex_q.rt),
      .mem_i (mem_q),
      .wb_i  (wb_q),
      .sel_o (fwd_b_o)
   );

   assign stall_o    = freeze || load_use;
   assign mul_busy_o = freeze && ex_q.mul;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Table-driven bench for fwd_scoreboard: one instance with defaults and one
// with ZERO_REG=0 / MUL_LAT=1, sharing the same ID-stage stimulus.
module tb_fwd_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [4:0] rs, rt, rd;
   logic       we, ld, mu, ur;
   logic [1:0] fa, fb, za, zb;
   logic       st, mb, zst, zmb;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string      nm;
      logic       fl;
      logic [4:0] rs, rt, rd;
      logic       we, ld, mu, ur;
      logic [1:0] ea, eb;
      logic       es, em;
      logic       cz;
      logic [1:0] za, zb;
      logic       zs;
   } vec_t;

   typedef struct {
      string      nm;
      logic [1:0] ea, eb;
      logic       es, em;
      logic       cz;
      logic [1:0] za, zb;
      logic       zs;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   fwd_scoreboard #(
      .REG_W   (5),
      .MUL_LAT (4),
      .ZERO_REG(1)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush),
      .id_rs_i    (rs),
      .id_rt_i    (rt),
      .id_rd_i    (rd),
      .id_we_i    (we),
      .id_load_i  (ld),
      .id_mul_i   (mu),
      .id_use_rt_i(ur),
      .fwd_a_o    (fa),
      .fwd_b_o    (fb),
      .stall_o    (st),
      .mul_busy_o (mb)
   );

   fwd_scoreboard #(
      .REG_W   (5),
      .MUL_LAT (1),
      .ZERO_REG(0)
   ) dut_z0 (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush),
      .id_rs_i    (rs),
      .id_rt_i    (rt),
      .id_rd_i    (rd),
      .id_we_i    (we),
      .id_load_i  (ld),
      .id_mul_i   (mu),
      .id_use_rt_i(ur),
      .fwd_a_o    (za),
      .fwd_b_o    (zb),
      .stall_o    (zst),
      .mul_busy_o (zmb)
   );

   task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(string nm, logic f, int s, int t, int d, logic w, logic l,
                               logic m, logic u, logic [1:0] ea, logic [1:0] eb,
                               logic es, logic em);
      vec_t v;
      v.nm = nm; v.fl = f;
      v.rs = 5'(s); v.rt = 5'(t); v.rd = 5'(d);
      v.we = w; v.ld = l; v.mu = m; v.ur = u;
      v.ea = ea; v.eb = eb; v.es = es; v.em = em;
      v.cz = 1'b0; v.za = 2'b00; v.zb = 2'b00; v.zs = 1'b0;
      return v;
   endfunction

   function automatic vec_t alu(string nm, int d, int s, int t, logic [1:0] ea, logic [1:0] eb,
                                logic es, logic em);
      return mk(nm, 1'b0, s, t, d, 1'b1, 1'b0, 1'b0, 1'b1, ea, eb, es, em);
   endfunction

   function automatic vec_t lw(string nm, int d, int s, logic [1:0] ea, logic [1:0] eb,
                               logic es, logic em);
      return mk(nm, 1'b0, s, 0, d, 1'b1, 1'b1, 1'b0, 1'b0, ea, eb, es, em);
   endfunction

   function automatic vec_t mul(string nm, int d, int s, int t, logic [1:0] ea, logic [1:0] eb,
                                logic es, logic em);
      return mk(nm, 1'b0, s, t, d, 1'b1, 1'b0, 1'b1, 1'b1, ea, eb, es, em);
   endfunction

   function automatic vec_t nop(string nm, logic [1:0] ea, logic [1:0] eb, logic es, logic em);
      return mk(nm, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, es, em);
   endfunction

   function automatic vec_t fl(vec_t v);
      v.fl = 1'b1;
      return v;
   endfunction

   function automatic vec_t zchk(vec_t v, logic [1:0] a, logic [1:0] b, logic s);
      v.cz = 1'b1; v.za = a; v.zb = b; v.zs = s;
      return v;
   endfunction

   task automatic drive_nop();
      flush = 1'b0; rs = '0; rt = '0; rd = '0;
      we = 1'b0; ld = 1'b0; mu = 1'b0; ur = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      drive_nop();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run_seq();
      vec_t v;
      exp_t e;
      while (tbl.size() > 0) begin
         v = tbl.pop_front();
         @(posedge clk); #1;
         flush = v.fl; rs = v.rs; rt = v.rt; rd = v.rd;
         we = v.we; ld = v.ld; mu = v.mu; ur = v.ur;
         e.nm = v.nm; e.ea = v.ea; e.eb = v.eb; e.es = v.es; e.em = v.em;
         e.cz = v.cz; e.za = v.za; e.zb = v.zb; e.zs = v.zs;
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         chk({e.nm, ".fwd_a"}, fa, e.ea);
         chk({e.nm, ".fwd_b"}, fb, e.eb);
         chk({e.nm, ".stall"}, {1'b0, st}, {1'b0, e.es});
         chk({e.nm, ".busy"}, {1'b0, mb}, {1'b0, e.em});
         if (e.cz) begin
            chk({e.nm, ".z0_fwd_a"}, za, e.za);
            chk({e.nm, ".z0_fwd_b"}, zb, e.zb);
            chk({e.nm, ".z0_stall"}, {1'b0, zst}, {1'b0, e.zs});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with a load-use-looking instruction in ID: outputs must stay idle.
      rst = 1'b1;
      drive_nop();
      rs = 5'd2; rd = 5'd2; we = 1'b1; ld = 1'b1;
      @(negedge clk);
      chk("reset.fwd_a", fa, 2'b00);
      chk("reset.fwd_b", fb, 2'b00);
      chk("reset.stall", {1'b0, st}, 2'b00);
      chk("reset.busy", {1'b0, mb}, 2'b00);
      @(posedge clk); #1;
      rst = 1'b0;
      drive_nop();
      @(negedge clk);
      chk("post_reset.stall", {1'b0, st}, 2'b00);
      chk("post_reset.fwd_a", fa, 2'b00);

      // EX/MEM and MEM/WB forwarding, MEM priority over WB.
      do_reset();
      tbl.push_back(alu("fwd.c0", 3, 1, 2, 2'b00, 2'b00, 0, 0));
      tbl.push_back(alu("fwd.c1", 4, 3, 5, 2'b00, 2'b00, 0, 0));
      tbl.push_back(nop("fwd.c2", 2'b10, 2'b00, 0, 0));
      tbl.push_back(alu("fwd.c3", 10, 1, 1, 2'b00, 2'b00, 0, 0));
      tbl.push_back(nop("fwd.c4", 2'b00, 2'b00, 0, 0));
      tbl.push_back(alu("fwd.c5", 11, 10, 4, 2'b00, 2'b00, 0, 0));
      tbl.push_back(nop("fwd.c6", 2'b01, 2'b00, 0, 0));
      tbl.push_back(alu("fwd.c7", 12, 1, 1, 2'b00, 2'b00, 0, 0));
      tbl.push_back(alu("fwd.c8", 12, 1, 1, 2'b00, 2'b00, 0, 0));
      tbl.push_back(alu("fwd.c9", 13, 12, 12, 2'b00, 2'b00, 0, 0));
      tbl.push_back(nop("fwd.c10", 2'b10, 2'b10, 0, 0));
      tbl.push_back(nop("fwd.c11", 2'b00, 2'b00, 0, 0));
      run_seq();

      // Load-use stalls on rs and on rt, use_rt gating, flushed load, r0 load.
      do_reset();
      tbl.push_back(lw("lu.c0", 2, 1, 2'b00, 2'b00, 0, 0));
      tbl.push_back(alu("lu.c1", 6, 2, 2, 2'b00, 2'b00, 1, 0));
      tbl.push_back(alu("lu.c2", 6, 2, 2, 2'b00, 2'b00, 0, 0));
      tbl.push_back(nop("lu.c3", 2'b01, 2'b01, 0, 0));
      tbl.push_back(lw("lu.c4", 5, 1, 2'b00, 2'b00, 0, 0));
      tbl.push_back(mk("lu.c5", 1'b0, 1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0));
      tbl.push_back(alu("lu.c6", 7, 1, 5, 2'b00, 2'b10, 0, 0));
      tbl.push_back(fl(lw("lu.c7", 9, 1, 2'b00, 2'b01, 0, 0)));
      tbl.push_back(alu("lu.c8", 10, 9, 9, 2'b00, 2'b00, 0, 0));
      tbl.push_back(lw("lu.c9", 0, 1, 2'b00, 2'b00, 0, 0));
      tbl.push_back(alu("lu.c10", 11, 0, 0, 2'b00, 2'b00, 0, 0));
      tbl.push_back(nop("lu.c11", 2'b00, 2'b00, 0, 0));
      tbl.push_back(lw("lu.c12", 3, 1, 2'b00, 2'b00, 0, 0));
      tbl.push_back(alu("lu.c13", 4, 1, 3, 2'b00, 2'b00, 1, 0));
      tbl.push_back(alu("lu.c14", 4, 1, 3, 2'b00, 2'b00, 0, 0));
      tbl.push_back(nop("lu.c15", 2'b00, 2'b01, 0, 0));
      run_seq();

      // r0 handling, compared across ZERO_REG=1 and ZERO_REG=0.
      do_reset();
      tbl.push_back(zchk(alu("zr.c0", 0, 1, 2, 2'b00, 2'b00, 0, 0), 2'b00, 2'b00, 0));
      tbl.push_back(zchk(alu("zr.c1", 7, 0, 0, 2'b00, 2'b00, 0, 0), 2'b00, 2'b00, 0));
      tbl.push_back(zchk(nop("zr.c2", 2'b00, 2'b00, 0, 0), 2'b10, 2'b10, 0));
      tbl.push_back(zchk(lw("zr.c3", 0, 1, 2'b00, 2'b00, 0, 0), 2'b01, 2'b01, 0));
      tbl.push_back(zchk(alu("zr.c4", 7, 0, 3, 2'b00, 2'b00, 0, 0), 2'b00, 2'b00, 1));
      run_seq();

      // MUL_LAT=4 freeze: three stall cycles, MEM bubbles, consumer forwarded from MEM.
      do_reset();
      tbl.push_back(alu("mul.c0", 5, 1, 1, 2'b00, 2'b00, 0, 0));
      tbl.push_back(mul("mul.c1", 8, 1, 2, 2'b00, 2'b00, 0, 0));
      tbl.push_back(alu("mul.c2", 9, 8, 5, 2'b00, 2'b00, 1, 1));
      tbl.push_back(alu("mul.c3", 9, 8, 5, 2'b00, 2'b00, 1, 1));
      tbl.push_back(alu("mul.c4", 9, 8, 5, 2'b00, 2'b00, 1, 1));
      tbl.push_back(alu("mul.c5", 9, 8, 5, 2'b00, 2'b00, 0, 0));
      tbl.push_back(nop("mul.c6", 2'b10, 2'b00, 0, 0));
      run_seq();

      // flush_i held through a freeze takes effect only on the advance cycle.
      do_reset();
      tbl.push_back(mul("mfl.c0", 8, 1, 2, 2'b00, 2'b00, 0, 0));
      tbl.push_back(fl(alu("mfl.c1", 9, 8, 8, 2'b00, 2'b00, 1, 1)));
      tbl.push_back(fl(alu("mfl.c2", 9, 8, 8, 2'b00, 2'b00, 1, 1)));
      tbl.push_back(fl(alu("mfl.c3", 9, 8, 8, 2'b00, 2'b00, 1, 1)));
      tbl.push_back(fl(alu("mfl.c4", 9, 8, 8, 2'b00, 2'b00, 0, 0)));
      tbl.push_back(alu("mfl.c5", 10, 8, 8, 2'b00, 2'b00, 0, 0));
      tbl.push_back(nop("mfl.c6", 2'b01, 2'b01, 0, 0));
      run_seq();

      // Reset pulse on the second freeze cycle aborts the freeze.
      do_reset();
      @(posedge clk); #1;
      drive_nop();
      rs = 5'd1; rt = 5'd2; rd = 5'd8; we = 1'b1; mu = 1'b1; ur = 1'b1;
      @(posedge clk); #1;
      drive_nop();
      @(negedge clk);
      chk("rstfrz.first.stall", {1'b0, st}, 2'b01);
      chk("rstfrz.first.busy", {1'b0, mb}, 2'b01);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rstfrz.async.stall", {1'b0, st}, 2'b00);
      chk("rstfrz.async.busy", {1'b0, mb}, 2'b00);
      chk("rstfrz.async.fwd_a", fa, 2'b00);
      chk("rstfrz.async.fwd_b", fb, 2'b00);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstfrz.release.stall", {1'b0, st}, 2'b00);
      chk("rstfrz.release.busy", {1'b0, mb}, 2'b00);
      @(posedge clk); #1;
      rs = 5'd8; rt = 5'd8; rd = 5'd9; we = 1'b1; ur = 1'b1;
      @(negedge clk);
      chk("rstfrz.adv.stall", {1'b0, st}, 2'b00);
      @(posedge clk); #1;
      drive_nop();
      @(negedge clk);
      chk("rstfrz.consumer.fwd_a", fa, 2'b00);
      chk("rstfrz.consumer.busy", {1'b0, mb}, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
